// File: rtl/uart_tx.sv
// UART transmitter with an AXI-Stream word input.
// Bit period, parity mode and stop-bit count are captured at the handshake, so a
// config change mid-frame has no effect until the next frame starts.
// ctsn only gates the start of a frame; a frame in progress always completes.
module uart_tx #(
   parameter int unsigned BAUD_PRESCALER = 25,
   parameter int unsigned PARITY         = 0,
   parameter int unsigned WORD_SIZE      = 8,
   parameter int unsigned STOP_BITS      = 0
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic [WORD_SIZE-1:0] s_axis_tdata,
   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,
   output logic                 txd,
   input  logic                 ctsn,
   output logic                 busy,
   input  logic [15:0]          prescaler_config,
   input  logic [2:0]           parity_config,
   input  logic                 stop_bits_config
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] START = 3'd1;
   localparam logic [2:0] DATA  = 3'd2;
   localparam logic [2:0] PAR   = 3'd3;
   localparam logic [2:0] STOP1 = 3'd4;
   localparam logic [2:0] STOP2 = 3'd5;

   // Reload value is period-1; a period of 0 behaves as 1.
   localparam logic [15:0] RESET_RELOAD =
      (BAUD_PRESCALER == 0) ? 16'd0 : 16'(BAUD_PRESCALER - 1);

   logic [2:0]           state_q, state_d;
   logic [15:0]          cnt_q, cnt_d;
   logic [3:0]           bit_q, bit_d;
   logic [WORD_SIZE-1:0] shift_q, shift_d;
   logic                 txd_q, txd_d;
   logic                 tready_q, tready_d;
   logic [15:0]          reload_q, reload_d;
   logic [2:0]           parity_q, parity_d;
   logic                 par_bit_q, par_bit_d;
   logic                 stop_q, stop_d;
   logic                 cts_meta_q, cts_sync_q;

   logic                 handshake;
   logic [15:0]          cfg_reload;
   logic                 cfg_par_bit;
   logic                 par_en;
   logic                 last_data_bit;

   assign handshake     = s_axis_tvalid & tready_q;
   assign cfg_reload    = (prescaler_config == 16'd0) ? 16'd0 : prescaler_config - 16'd1;
   assign par_en        = (parity_q >= 3'd1) && (parity_q <= 3'd4);
   assign last_data_bit = (bit_q == 4'(WORD_SIZE - 1));

   // Parity bit of the word being accepted, per the incoming parity mode.
   always_comb begin
      cfg_par_bit = 1'b0;
      case (parity_config)
         3'd1:    cfg_par_bit = ^s_axis_tdata;
         3'd2:    cfg_par_bit = ~^s_axis_tdata;
         3'd3:    cfg_par_bit = 1'b1;
         default: cfg_par_bit = 1'b0;
      endcase
   end

   // Frame sequencer: every bit lasts reload+1 cycles, reloaded at each boundary.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      txd_d     = txd_q;
      reload_d  = reload_q;
      parity_d  = parity_q;
      par_bit_d = par_bit_q;
      stop_d    = stop_q;
      if (state_q == IDLE) begin
         txd_d = 1'b1;
         if (handshake) begin
            state_d   = START;
            txd_d     = 1'b0;
            cnt_d     = cfg_reload;
            shift_d   = s_axis_tdata;
            reload_d  = cfg_reload;
            parity_d  = parity_config;
            par_bit_d = cfg_par_bit;
            stop_d    = stop_bits_config;
         end
      end else if (cnt_q != 16'd0) begin
         cnt_d = cnt_q - 16'd1;
      end else begin
         cnt_d = reload_q;
         case (state_q)
            START: begin
               state_d = DATA;
               txd_d   = shift_q[0];
               shift_d = shift_q >> 1;
               bit_d   = 4'd0;
            end
            DATA: begin
               if (!last_data_bit) begin
                  txd_d   = shift_q[0];
                  shift_d = shift_q >> 1;
                  bit_d   = bit_q + 4'd1;
               end else if (par_en) begin
                  state_d = PAR;
                  txd_d   = par_bit_q;
               end else begin
                  state_d = STOP1;
                  txd_d   = 1'b1;
               end
            end
            PAR: begin
               state_d = STOP1;
               txd_d   = 1'b1;
            end
            STOP1: begin
               state_d = stop_q ? STOP2 : IDLE;
               txd_d   = 1'b1;
            end
            default: begin
               state_d = IDLE;
               txd_d   = 1'b1;
            end
         endcase
      end
      // Registered off the synchronized ctsn, so tready first rises on the third edge.
      tready_d = (state_d == IDLE) && !cts_sync_q;
   end

   // State, datapath and ctsn synchronizer registers.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q    <= IDLE;
         cnt_q      <= 16'd0;
         bit_q      <= 4'd0;
         shift_q    <= '0;
         txd_q      <= 1'b1;
         tready_q   <= 1'b0;
         reload_q   <= RESET_RELOAD;
         parity_q   <= 3'(PARITY);
         par_bit_q  <= 1'b0;
         stop_q     <= 1'(STOP_BITS);
         cts_meta_q <= 1'b1;
         cts_sync_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         txd_q      <= txd_d;
         tready_q   <= tready_d;
         reload_q   <= reload_d;
         parity_q   <= parity_d;
         par_bit_q  <= par_bit_d;
         stop_q     <= stop_d;
         cts_meta_q <= ctsn;
         cts_sync_q <= cts_meta_q;
      end
   end

   assign txd           = txd_q;
   assign s_axis_tready = tready_q;
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frames are predicted from the word, parity mode
// and stop-bit count as a list of line levels, each held for P cycles.
module tb_uart_tx;

   localparam int WS = 8;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b1;
   logic [WS-1:0] s_axis_tdata = '0;
   logic          s_axis_tvalid = 1'b0;
   logic          s_axis_tready;
   logic          txd;
   logic          ctsn = 1'b0;
   logic          busy;
   logic [15:0]   prescaler_config = 16'd4;
   logic [2:0]    parity_config = 3'd0;
   logic          stop_bits_config = 1'b0;

   int n_total = 0;
   int n_pass  = 0;

   logic exp_bits[$];

   uart_tx #(
      .BAUD_PRESCALER(25),
      .PARITY        (0),
      .WORD_SIZE     (WS),
      .STOP_BITS     (0)
   ) dut (
      .aclk            (aclk),
      .aresetn         (aresetn),
      .s_axis_tdata    (s_axis_tdata),
      .s_axis_tvalid   (s_axis_tvalid),
      .s_axis_tready   (s_axis_tready),
      .txd             (txd),
      .ctsn            (ctsn),
      .busy            (busy),
      .prescaler_config(prescaler_config),
      .parity_config   (parity_config),
      .stop_bits_config(stop_bits_config)
   );

   always #5 aclk = ~aclk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   // Reference frame: start, data LSB first, optional parity, one or two stops.
   task automatic build_frame(input logic [WS-1:0] word, input int par, input int stop);
      int ones;
      exp_bits.delete();
      exp_bits.push_back(1'b0);
      for (int i = 0; i < WS; i++) exp_bits.push_back(word[i]);
      ones = $countones(word);
      case (par)
         1: exp_bits.push_back((ones % 2) == 1);
         2: exp_bits.push_back((ones % 2) == 0);
         3: exp_bits.push_back(1'b1);
         4: exp_bits.push_back(1'b0);
         default: ;
      endcase
      exp_bits.push_back(1'b1);
      if (stop != 0) exp_bits.push_back(1'b1);
   endtask

   // Called at a negedge; returns at the negedge right after the handshake edge.
   task automatic send(input logic [WS-1:0] word, input int presc, input int par,
                       input int stop, input bit hold, input string name);
      int k;
      s_axis_tdata     = word;
      prescaler_config = 16'(presc);
      parity_config    = 3'(par);
      stop_bits_config = 1'(stop);
      s_axis_tvalid    = 1'b1;
      k = 0;
      while (s_axis_tready !== 1'b1 && k < 200) begin
         @(negedge aclk);
         k++;
      end
      n_total++;
      if (s_axis_tready !== 1'b1)
         $display("FAIL %s handshake: tready=%b expected 1", name, s_axis_tready);
      else n_pass++;
      @(negedge aclk);
      if (!hold) s_axis_tvalid = 1'b0;
   endtask

   // Walks one frame cycle by cycle, then checks the single idle cycle after it.
   task automatic expect_frame(input int p, input bit scramble, input string name);
      int n;
      n = exp_bits.size();
      for (int c = 0; c < n * p; c++) begin
         if (scramble && c == 1) begin
            prescaler_config = 16'($urandom);
            parity_config    = 3'($urandom);
            stop_bits_config = 1'($urandom);
            s_axis_tdata     = WS'($urandom);
         end
         n_total++;
         if (txd !== exp_bits[c / p])
            $display("FAIL %s txd cycle %0d: got %b expected %b", name, c, txd, exp_bits[c / p]);
         else n_pass++;
         n_total++;
         if (busy !== 1'b1) $display("FAIL %s busy cycle %0d: got %b expected 1", name, c, busy);
         else n_pass++;
         n_total++;
         if (s_axis_tready !== 1'b0)
            $display("FAIL %s tready cycle %0d: got %b expected 0", name, c, s_axis_tready);
         else n_pass++;
         @(negedge aclk);
      end
      n_total++;
      if (txd !== 1'b1) $display("FAIL %s idle txd: got %b expected 1", name, txd);
      else n_pass++;
      n_total++;
      if (busy !== 1'b0) $display("FAIL %s idle busy: got %b expected 0", name, busy);
      else n_pass++;
      n_total++;
      if (s_axis_tready !== 1'b1) $display("FAIL %s idle tready: got %b expected 1", name, s_axis_tready);
      else n_pass++;
   endtask

   task automatic test_reset();
      int k;
      aresetn = 1'b0;
      #2;
      n_total++;
      if (txd !== 1'b1) $display("FAIL reset txd: got %b expected 1", txd); else n_pass++;
      n_total++;
      if (s_axis_tready !== 1'b0) $display("FAIL reset tready: got %b expected 0", s_axis_tready);
      else n_pass++;
      n_total++;
      if (busy !== 1'b0) $display("FAIL reset busy: got %b expected 0", busy); else n_pass++;
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
      for (int e = 1; e <= 2; e++) begin
         @(negedge aclk);
         n_total++;
         if (s_axis_tready !== 1'b0)
            $display("FAIL reset tready edge %0d: got %b expected 0", e, s_axis_tready);
         else n_pass++;
      end
      k = 0;
      while (s_axis_tready !== 1'b1 && k < 10) begin
         @(negedge aclk);
         k++;
      end
      n_total++;
      if (s_axis_tready !== 1'b1) $display("FAIL reset tready rise: got %b expected 1", s_axis_tready);
      else n_pass++;
   endtask

   task automatic test_basic();
      send(8'hA5, 4, 0, 0, 1'b0, "basic_a5");
      build_frame(8'hA5, 0, 0);
      expect_frame(4, 1'b1, "basic_a5");
   endtask

   task automatic test_parity();
      send(8'h07, 2, 1, 0, 1'b0, "par_even");
      build_frame(8'h07, 1, 0);
      expect_frame(2, 1'b0, "par_even");
      send(8'h00, 2, 2, 0, 1'b0, "par_odd");
      build_frame(8'h00, 2, 0);
      expect_frame(2, 1'b0, "par_odd");
      send(8'hFF, 2, 4, 0, 1'b0, "par_space");
      build_frame(8'hFF, 4, 0);
      expect_frame(2, 1'b0, "par_space");
      send(8'h12, 2, 3, 0, 1'b0, "par_mark");
      build_frame(8'h12, 3, 0);
      expect_frame(2, 1'b0, "par_mark");
   endtask

   task automatic test_two_stop();
      send(8'h00, 3, 0, 1, 1'b0, "two_stop");
      build_frame(8'h00, 0, 1);
      expect_frame(3, 1'b0, "two_stop");
   endtask

   task automatic test_cts();
      int k;
      ctsn = 1'b1;
      s_axis_tvalid = 1'b0;
      repeat (4) @(negedge aclk);
      s_axis_tdata     = 8'h5C;
      prescaler_config = 16'd2;
      parity_config    = 3'd0;
      stop_bits_config = 1'b0;
      s_axis_tvalid    = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge aclk);
         n_total++;
         if (s_axis_tready !== 1'b0 || txd !== 1'b1)
            $display("FAIL cts_hold cycle %0d: tready=%b txd=%b expected tready 0 txd 1",
                     c, s_axis_tready, txd);
         else n_pass++;
      end
      ctsn = 1'b0;
      k = 0;
      while (s_axis_tready !== 1'b1 && k < 10) begin
         @(negedge aclk);
         k++;
      end
      n_total++;
      if (s_axis_tready !== 1'b1 || k > 3)
         $display("FAIL cts_release: tready=%b after %0d cycles expected 1 within 3", s_axis_tready, k);
      else n_pass++;
      // ctsn rises in the handshake cycle: the handshake must still stand.
      ctsn = 1'b1;
      @(negedge aclk);
      s_axis_tvalid = 1'b0;
      ctsn = 1'b0;
      build_frame(8'h5C, 0, 0);
      expect_frame(2, 1'b0, "cts_frame");
   endtask

   task automatic test_random();
      logic [WS-1:0] w;
      int pr, pa, st;
      for (int i = 0; i < 8; i++) begin
         w  = WS'($urandom);
         pr = $urandom_range(0, 5);
         pa = $urandom_range(0, 7);
         st = $urandom_range(0, 1);
         send(w, pr, pa, st, 1'b0, "random");
         build_frame(w, pa, st);
         expect_frame((pr == 0) ? 1 : pr, 1'b1, "random");
      end
   endtask

   task automatic test_back_to_back();
      send(8'h3A, 2, 1, 0, 1'b1, "b2b_first");
      s_axis_tdata = 8'hC4;
      build_frame(8'h3A, 1, 0);
      expect_frame(2, 1'b0, "b2b_first");
      @(negedge aclk);
      s_axis_tvalid = 1'b0;
      build_frame(8'hC4, 1, 0);
      expect_frame(2, 1'b0, "b2b_second");
   endtask

   task automatic test_reset_mid_frame();
      send(8'h3C, 4, 0, 0, 1'b0, "rst_mid");
      repeat (13) @(negedge aclk);
      #2 aresetn = 1'b0;
      #1;
      n_total++;
      if (txd !== 1'b1) $display("FAIL rst_mid txd: got %b expected 1", txd); else n_pass++;
      n_total++;
      if (busy !== 1'b0) $display("FAIL rst_mid busy: got %b expected 0", busy); else n_pass++;
      n_total++;
      if (s_axis_tready !== 1'b0) $display("FAIL rst_mid tready: got %b expected 0", s_axis_tready);
      else n_pass++;
      @(negedge aclk);
      aresetn = 1'b1;
      send(8'h96, 25, 0, 0, 1'b0, "rst_default");
      build_frame(8'h96, 0, 0);
      expect_frame(25, 1'b0, "rst_default");
   endtask

   initial begin
      #1;
      test_reset();
      test_basic();
      test_parity();
      test_two_stop();
      test_cts();
      test_random();
      test_back_to_back();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
